// File: rtl/fetch_stage_if.sv
// Fetch-stage bus definitions.
//   fetch_pkg::fetch_t : fetch/decode pipeline register bundle {instr, pc, npc, valid}
//   fetch_stage_if     : groups the instruction-memory handshake, pipeline control
//                        inputs and fetch-stage outputs.
//     master modport : the fetch stage (drives imemREN/imemaddr/fetch_p/fetch_count/halted)
//     slave  modport : the environment (memory, decode, hazard and branch logic)
package fetch_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } fetch_t;
endpackage

interface fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic               ihit;
  logic               dhit;
  logic [31:0]        imemload;
  logic               flush;
  logic               freeze;
  logic               redirect_valid;
  logic [31:0]        redirect_addr;
  logic               halt_seen;
  logic               imemREN;
  logic [31:0]        imemaddr;
  fetch_pkg::fetch_t  fetch_p;
  logic [CNT_W-1:0]   fetch_count;
  logic               halted;

  modport master (
    input  ihit, dhit, imemload, flush, freeze, redirect_valid, redirect_addr, halt_seen,
    output imemREN, imemaddr, fetch_p, fetch_count, halted
  );

  modport slave (
    output ihit, dhit, imemload, flush, freeze, redirect_valid, redirect_addr, halt_seen,
    input  imemREN, imemaddr, fetch_p, fetch_count, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads, latches
// returned instructions into the fetch/decode register and applies redirects,
// flush, freeze and halt. Counts delivered bundles (saturating).
// Ports:
//   CLK  : pipeline clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : fetch_stage_if.master (memory handshake, control inputs, fetch_p,
//          fetch_count, halted)
//
// state  | meaning
// RUN    | normal fetch
// PEND   | redirect captured while frozen, applied on first unfrozen edge
// HALTED | fetch stopped, only reset leaves
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          CNT_W   = 32
) (
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.master bus
);
  import fetch_pkg::*;

  typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_addr_q, pend_addr_d;
  fetch_t           fetch_q, fetch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      npc;

  assign npc = pc_q + 32'd4;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      pc_q        <= PC_INIT;
      pend_addr_q <= '0;
      fetch_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      fetch_q     <= fetch_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    fetch_d     = fetch_q;
    cnt_d       = cnt_q;

    if (state_q != HALTED) begin
      if (bus.halt_seen) begin
        state_d     = HALTED;
        fetch_d     = '0;
        pend_addr_d = '0;
      end else begin
        // PC update: a held redirect takes effect on the first unfrozen edge;
        // otherwise the PC advances only when an instruction is accepted.
        if (!bus.freeze && state_q == PEND) begin
          pc_d        = pend_addr_q;
          pend_addr_d = '0;
          state_d     = RUN;
        end else if (!bus.freeze && bus.ihit && !bus.flush) begin
          pc_d = npc;
        end

        // A fresh redirect overrides both of the above.
        if (bus.redirect_valid) begin
          if (bus.freeze) begin
            pend_addr_d = bus.redirect_addr;
            state_d     = PEND;
          end else begin
            pc_d        = bus.redirect_addr;
            pend_addr_d = '0;
            state_d     = RUN;
          end
        end

        // Pipeline register: flush beats freeze; the word fetched on the
        // PEND-apply edge belongs to the wrong path and is dropped.
        if (bus.flush || (state_q == PEND && !bus.freeze)) begin
          fetch_d = '0;
        end else if (!bus.freeze) begin
          if (bus.ihit) begin
            fetch_d = '{instr: bus.imemload, pc: pc_q, npc: npc, valid: 1'b1};
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else if (bus.dhit) begin
            fetch_d = '0;
          end
        end
      end
    end
  end

  assign bus.imemaddr    = pc_q;
  assign bus.imemREN     = (state_q != HALTED);
  assign bus.fetch_p     = fetch_q;
  assign bus.fetch_count = cnt_q;
  assign bus.halted      = (state_q == HALTED);
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_stage_if #(.CNT_W(32)) bus ();
  fetch_stage_if #(.CNT_W(4))  bus4 ();

  fetch_stage #(.PC_INIT(32'h0), .CNT_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  fetch_stage #(.PC_INIT(32'h0), .CNT_W(4))  dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

  typedef struct {
    logic [5:0]  ctrl;   // {ihit, dhit, flush, freeze, redirect_valid, halt_seen}
    logic [31:0] raddr;
    logic [31:0] load;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_valid;
    logic [31:0] e_cnt;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(logic [5:0] c, logic [31:0] ra, logic [31:0] ld,
                              logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                              logic [31:0] en, logic ev, logic [31:0] ec, logic eh);
    vec_t v;
    v.ctrl = c; v.raddr = ra; v.load = ld;
    v.e_addr = ea; v.e_instr = ei; v.e_pc = ep; v.e_npc = en;
    v.e_valid = ev; v.e_cnt = ec; v.e_halt = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] c, input logic [31:0] ra, input logic [31:0] ld);
    @(negedge CLK);
    {bus.ihit, bus.dhit, bus.flush, bus.freeze, bus.redirect_valid, bus.halt_seen} = c;
    bus.redirect_addr = ra;
    bus.imemload      = ld;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string nm, input vec_t v);
    chk({nm, " addr"},  bus.imemaddr, v.e_addr);
    chk({nm, " instr"}, bus.fetch_p.instr, v.e_instr);
    chk({nm, " pc"},    bus.fetch_p.pc, v.e_pc);
    chk({nm, " npc"},   bus.fetch_p.npc, v.e_npc);
    chk({nm, " valid"}, 32'(bus.fetch_p.valid), 32'(v.e_valid));
    chk({nm, " cnt"},   bus.fetch_count, v.e_cnt);
    chk({nm, " halt"},  32'(bus.halted), 32'(v.e_halt));
    chk({nm, " ren"},   32'(bus.imemREN), 32'(!v.e_halt));
  endtask

  initial begin
    {bus.ihit, bus.dhit, bus.flush, bus.freeze, bus.redirect_valid, bus.halt_seen} = '0;
    bus.redirect_addr = '0; bus.imemload = '0;
    {bus4.ihit, bus4.dhit, bus4.flush, bus4.freeze, bus4.redirect_valid, bus4.halt_seen} = '0;
    bus4.redirect_addr = '0; bus4.imemload = '0;

    //                ih dh fl fz rv hs  raddr         load          addr          instr         pc            npc           v     cnt  halt
    vecs.push_back(mk(6'b000000, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 0, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'hA000_0001, 32'h4,       32'hA000_0001, 32'h0,       32'h4,        1'b1, 1, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'hB000_0002, 32'h8,       32'hB000_0002, 32'h4,       32'h8,        1'b1, 2, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'hC000_0003, 32'hC,       32'hC000_0003, 32'h8,       32'hC,        1'b1, 3, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'hD000_0004, 32'h10,      32'hD000_0004, 32'hC,       32'h10,       1'b1, 4, 1'b0));
    vecs.push_back(mk(6'b100100, 32'h0,   32'hE000_0005, 32'h10,      32'hD000_0004, 32'hC,       32'h10,       1'b1, 4, 1'b0));
    vecs.push_back(mk(6'b100100, 32'h0,   32'hE000_0005, 32'h10,      32'hD000_0004, 32'hC,       32'h10,       1'b1, 4, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'hF000_0006, 32'h14,      32'hF000_0006, 32'h10,      32'h14,       1'b1, 5, 1'b0));
    vecs.push_back(mk(6'b010000, 32'h0,   32'h0,        32'h14,       32'h0,        32'h0,        32'h0,        1'b0, 5, 1'b0));
    vecs.push_back(mk(6'b100010, 32'h40,  32'h1111_1111, 32'h40,      32'h1111_1111, 32'h14,      32'h18,       1'b1, 6, 1'b0));
    vecs.push_back(mk(6'b101010, 32'h200, 32'h2222_2222, 32'h200,     32'h0,        32'h0,        32'h0,        1'b0, 6, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'h3333_3333, 32'h204,     32'h3333_3333, 32'h200,     32'h204,      1'b1, 7, 1'b0));
    vecs.push_back(mk(6'b100110, 32'h300, 32'h4444_4444, 32'h204,     32'h3333_3333, 32'h200,     32'h204,      1'b1, 7, 1'b0));
    vecs.push_back(mk(6'b100110, 32'h400, 32'h5555_5555, 32'h204,     32'h3333_3333, 32'h200,     32'h204,      1'b1, 7, 1'b0));
    vecs.push_back(mk(6'b000100, 32'h0,   32'h0,        32'h204,      32'h3333_3333, 32'h200,     32'h204,      1'b1, 7, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'h6666_6666, 32'h400,     32'h0,        32'h0,        32'h0,        1'b0, 7, 1'b0));
    vecs.push_back(mk(6'b100000, 32'h0,   32'h7777_7777, 32'h404,     32'h7777_7777, 32'h400,     32'h404,      1'b1, 8, 1'b0));
    vecs.push_back(mk(6'b001100, 32'h0,   32'h0,        32'h404,      32'h0,        32'h0,        32'h0,        1'b0, 8, 1'b0));
    vecs.push_back(mk(6'b100010, 32'h80,  32'h8888_8888, 32'h80,      32'h8888_8888, 32'h404,     32'h408,      1'b1, 9, 1'b0));
    vecs.push_back(mk(6'b100001, 32'h0,   32'h9999_9999, 32'h80,      32'h0,        32'h0,        32'h0,        1'b0, 9, 1'b1));

    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst addr", bus.imemaddr, 32'h0);
    chk("rst fetch_p", 32'(bus.fetch_p.valid) | bus.fetch_p.instr | bus.fetch_p.pc | bus.fetch_p.npc, 32'h0);
    chk("rst ren", 32'(bus.imemREN), 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctrl, vecs[i].raddr, vecs[i].load);
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // HALTED ignores everything
    for (int i = 0; i < 10; i++) begin
      drive(6'b111010 ^ {3'b000, i[0], 2'b00}, 32'h1000 + 32'(i), 32'hDEAD_0000 + 32'(i));
      chk_all($sformatf("halt%0d", i),
              mk(6'b0, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0, 32'h0, 1'b0, 9, 1'b1));
    end

    // asynchronous reset out of HALTED
    @(negedge CLK);
    {bus.ihit, bus.dhit, bus.flush, bus.freeze, bus.redirect_valid, bus.halt_seen} = '0;
    RST = 1'b1;
    #1;
    chk("arst addr", bus.imemaddr, 32'h0);
    chk("arst halted", 32'(bus.halted), 32'h0);
    chk("arst ren", 32'(bus.imemREN), 32'h1);
    chk("arst cnt", bus.fetch_count, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    // PC wrap
    drive(6'b000010, 32'hFFFF_FFFC, 32'h0);
    chk("wrap pc", bus.imemaddr, 32'hFFFF_FFFC);
    drive(6'b100000, 32'h0, 32'h5A5A_5A5A);
    chk("wrap instr", bus.fetch_p.instr, 32'h5A5A_5A5A);
    chk("wrap fpc", bus.fetch_p.pc, 32'hFFFF_FFFC);
    chk("wrap npc", bus.fetch_p.npc, 32'h0);
    chk("wrap addr", bus.imemaddr, 32'h0);
    chk("wrap cnt", bus.fetch_count, 32'h1);

    // a redirect held in PEND must not survive reset
    drive(6'b000110, 32'h500, 32'h0);
    chk("pend hold", bus.imemaddr, 32'h0);
    @(negedge CLK);
    {bus.ihit, bus.dhit, bus.flush, bus.freeze, bus.redirect_valid, bus.halt_seen} = '0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive(6'b100000, 32'h0, 32'h1234_5678);
    chk("post-rst addr", bus.imemaddr, 32'h4);
    chk("post-rst valid", 32'(bus.fetch_p.valid), 32'h1);
    chk("post-rst cnt", bus.fetch_count, 32'h1);

    // 4-bit counter saturation
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      bus4.ihit = 1'b1;
      bus4.imemload = 32'(k);
      @(posedge CLK);
      #1;
      if (k >= 14) chk($sformatf("sat k%0d", k), 32'(bus4.fetch_count), (k > 15) ? 32'd15 : 32'(k));
    end
    chk("sat pc", bus4.imemaddr, 32'd64);
    @(negedge CLK);
    bus4.ihit = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage pipeline: the producer of the fetch_t bundle consumed by the decode stage.
- Owns the PC and drives the instruction-memory request.
- Latches each returned instruction with its pc/npc into the fetch/decode pipeline register.
- Applies branch/jump redirects, flush, freeze and halt, and counts delivered instructions for the perf/verification hooks.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
CNT_W, 32, width of the delivered-instruction counter (saturating).

Ports:
CLK  input  1  pipeline clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
ihit  input  1  instruction memory returned imemload for imemaddr this cycle
dhit  input  1  data access completed; downstream stages advance this cycle
imemload  input  32  instruction word for current imemaddr
flush  input  1  squash the fetch/decode register (branch/jump resolved)
freeze  input  1  hazard stall from downstream; hold PC and fetch_p
redirect_valid  input  1  load redirect_addr into PC
redirect_addr  input  32  redirect target, word aligned
halt_seen  input  1  halt instruction reached decode
imemREN  output  1  instruction read request
imemaddr  output  32  instruction address (= pc)
fetch_p  output  fetch_t  registered bundle {instr[31:0], pc[31:0], npc[31:0], valid}
fetch_count  output  CNT_W  number of valid bundles delivered
halted  output  1  fetch stopped

Behaviour:
Reset (async, RST=1):
- pc=PC_INIT; state=RUN.
- fetch_p = all zero, valid=0.
- pend_valid=0, pend_addr=0, fetch_count=0, halted=0.
- imemREN=1 in the first cycle after reset release.

Combinational outputs:
- imemaddr=pc.
- imemREN = (state != HALTED).
- npc = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.

States:
- RUN: normal fetch.
- PEND: a redirect is held while frozen.
- HALTED: terminal until reset.

Per-edge priority in RUN/PEND (highest first): halt_seen, flush/redirect, freeze, ihit, dhit.
1. halt_seen: state=HALTED, halted=1, fetch_p becomes a bubble (all zero, valid=0), pc holds. Any pending redirect is dropped.
2. flush:
   - fetch_p becomes a bubble, even if freeze=1.
   - If redirect_valid and freeze=0: pc=redirect_addr, state=RUN.
   - If redirect_valid and freeze=1: pend_addr=redirect_addr, state=PEND.
   - An instruction returned by ihit in the same cycle is discarded.
3. redirect_valid without flush: same pc/pending rules as flush; fetch_p is treated per rules 4-6.
4. freeze=1: pc and fetch_p hold. An ihit this cycle is dropped, and the same pc is refetched later.
5. ihit=1, freeze=0:
   - fetch_p = {imemload, pc, npc, 1}.
   - pc = npc, unless state=PEND, in which case pc=pend_addr, pend cleared, state=RUN.
   - fetch_count increments, saturating at all-ones.
6. ihit=0, dhit=1, freeze=0: fetch_p becomes a bubble (decode consumed the old bundle). pc holds, or takes pend_addr if in PEND.
7. Otherwise everything holds.

PEND details:
- A PEND redirect is applied on the first edge with freeze=0, regardless of ihit.
- Any instruction fetched in that cycle is discarded and fetch_p becomes a bubble.
- A newer redirect in PEND overwrites pend_addr.

HALTED:
- imemREN=0; pc, fetch_p and fetch_count hold.
- All inputs are ignored; only RST exits.

Reset mid-operation: asserting RST at any time (including during PEND, HALTED or an outstanding ihit) asynchronously returns to the reset values. No pending state survives.

fetch_count changes only on a valid bundle load (rule 5).

Test Plan:
- Reset release with PC_INIT=0, ihit held high for 3 cycles, imemload=A,B,C → fetch_p = {A,0,4,1}, {B,4,8,1}, {C,8,12,1}; fetch_count=3; imemaddr=12.
- ihit=1 with freeze=1 for 2 cycles at pc=0x10 → pc stays 0x10, fetch_p unchanged, fetch_count unchanged; after freeze drops with ihit=1, fetch_p.pc=0x10.
- flush + redirect_valid, redirect_addr=0x200, with ihit=1 at pc=0x40 → next cycle fetch_p.valid=0, instr=0, imemaddr=0x200, fetch_count not incremented.
- redirect 0x300 during freeze, then a second redirect 0x400 while still frozen, then freeze drops with ihit=1 → pc=0x400, that cycle's instruction discarded, fetch_p bubble, state RUN.
- halt_seen at pc=0x80 → halted=1, imemREN=0, fetch_p bubble; 10 further cycles of ihit, redirect and flush leave pc=0x80 and fetch_count frozen; RST restores pc=PC_INIT, halted=0.
- pc=0xFFFF_FFFC with ihit → fetch_p.npc=0, next imemaddr=0. Separately, fetch_count preset near saturation (CNT_W=4, 15 delivered) → stays 15 after a further ihit.
